// File: rtl/display_arbiter_if.sv
// rtl/display_arbiter_if.sv - request/value/grant bundle between debug taps and the display arbiter
//
// Purpose: groups the requester side (req, hold, d0..d3) and the display side
// (grant, seg_out, active, slot_done) of the display arbiter into one bundle.
// Ports (signals):
//   req       4   request per source, bit i = source i wants the display
//   hold      1   freeze the current grant
//   d0..d3    16  display value of source 0..3
//   grant     4   one-hot grant, zero when nobody owns the display
//   seg_out   16  registered value for the display controller
//   active    1   |grant
//   slot_done 1   one-cycle pulse when a slot expires on timeout
// Modports: master = requester side / environment, slave = arbiter.

interface display_arbiter_if;
   logic [3:0]  req;
   logic        hold;
   logic [15:0] d0;
   logic [15:0] d1;
   logic [15:0] d2;
   logic [15:0] d3;
   logic [3:0]  grant;
   logic [15:0] seg_out;
   logic        active;
   logic        slot_done;

   modport master (
      output req, hold, d0, d1, d2, d3,
      input  grant, seg_out, active, slot_done
   );

   modport slave (
      input  req, hold, d0, d1, d2, d3,
      output grant, seg_out, active, slot_done
   );
endinterface

// File: rtl/display_arbiter.sv
// rtl/display_arbiter.sv - round-robin arbiter sharing one seven-segment display among four sources
//
// Purpose: grants the 16-bit display path to one of four requesters for a
// fixed slot of HOLD_CYCLES clocks, rotating round-robin, with a one-cycle
// break-before-make gap (NEXT) plus one IDLE arbitration cycle between grants.
// Ports:
//   clk    in  system clock, rising edge
//   reset  in  synchronous active-low reset
//   bus    slave modport of display_arbiter_if (req/hold/d0..d3 in,
//          grant/seg_out/active/slot_done out, all outputs registered)
// Parameters:
//   HOLD_CYCLES  cycles a grant is held on timeout (>= 2)
//   CNT_W        slot counter width, 2**CNT_W > HOLD_CYCLES

module display_arbiter #(
   parameter int HOLD_CYCLES = 50_000_000,
   parameter int CNT_W       = 26
) (
   input logic              clk,
   input logic              reset,
   display_arbiter_if.slave bus
);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      SHOW = 2'd1,
      NEXT = 2'd2
   } state_t;

   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(HOLD_CYCLES - 1);

   state_t           state;
   logic [CNT_W-1:0] cnt;
   logic [1:0]       ptr;
   logic [1:0]       winner;

   logic [1:0]       pick;
   logic             pick_valid;
   logic [1:0]       idx;
   logic [15:0]      d_sel;

   // Round-robin pick: scan ptr, ptr+1, ... (mod 4). The loop runs from the
   // farthest offset down so the closest set bit to ptr is written last.
   always_comb begin
      pick       = ptr;
      pick_valid = 1'b0;
      idx        = ptr;
      for (int i = 3; i >= 0; i--) begin
         idx = ptr + 2'(i);
         if (bus.req[idx]) begin
            pick       = idx;
            pick_valid = 1'b1;
         end
      end
   end

   always_comb begin
      d_sel = bus.d0;
      case (winner)
         2'd0:    d_sel = bus.d0;
         2'd1:    d_sel = bus.d1;
         2'd2:    d_sel = bus.d2;
         default: d_sel = bus.d3;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state         <= IDLE;
         cnt           <= '0;
         ptr           <= '0;
         winner        <= '0;
         bus.grant     <= '0;
         bus.seg_out   <= '0;
         bus.active    <= 1'b0;
         bus.slot_done <= 1'b0;
      end else begin
         bus.slot_done <= 1'b0;
         case (state)
            IDLE: begin
               // seg_out is left alone so the last value stays on the display
               if (pick_valid) begin
                  winner     <= pick;
                  bus.grant  <= 4'b0001 << pick;
                  bus.active <= 1'b1;
                  cnt        <= '0;
                  state      <= SHOW;
               end
            end

            SHOW: begin
               // live tracking of the granted source's value
               bus.seg_out <= d_sel;
               // saturate so a long hold cannot wrap the slot timer
               if (cnt != CNT_LAST) begin
                  cnt <= cnt + CNT_W'(1);
               end
               // early release wins over timeout and never pulses slot_done
               if (!bus.req[winner]) begin
                  bus.grant  <= '0;
                  bus.active <= 1'b0;
                  state      <= NEXT;
               end else if (cnt == CNT_LAST && !bus.hold) begin
                  bus.grant     <= '0;
                  bus.active    <= 1'b0;
                  bus.slot_done <= 1'b1;
                  state         <= NEXT;
               end
            end

            NEXT: begin
               ptr   <= winner + 2'd1;
               state <= IDLE;
            end

            default: begin
               bus.grant  <= '0;
               bus.active <= 1'b0;
               state      <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_display_arbiter.sv
// tb/tb_display_arbiter.sv - scoreboard bench for display_arbiter with HOLD_CYCLES=4

module tb_display_arbiter;

   typedef struct {
      int          idx;
      logic [3:0]  grant;
      logic [15:0] seg;
      logic        sd;
   } exp_t;

   logic        clk;
   logic        reset;
   logic [63:0] dv;
   exp_t        q[$];
   int          checks;
   int          errors;
   int          step_no;

   display_arbiter_if bus();

   display_arbiter #(
      .HOLD_CYCLES (4),
      .CNT_W       (3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   // Drive inputs just after a falling edge; the expected outputs after the
   // following rising edge are queued and checked by the monitor on the next
   // falling edge.
   task automatic step(input logic rst, input logic [3:0] r, input logic h,
                       input logic [3:0] eg, input logic [15:0] es, input logic esd);
      exp_t e;
      @(negedge clk);
      #1;
      reset    = rst;
      bus.req  = r;
      bus.hold = h;
      bus.d0   = dv[15:0];
      bus.d1   = dv[31:16];
      bus.d2   = dv[47:32];
      bus.d3   = dv[63:48];
      e.idx    = step_no;
      e.grant  = eg;
      e.seg    = es;
      e.sd     = esd;
      q.push_back(e);
      step_no++;
   endtask

   // One full timeout slot: IDLE grant cycle, three SHOW cycles, expiry, NEXT.
   task automatic slot(input logic [3:0] r, input logic [3:0] g,
                       input logic [15:0] prev, input logic [15:0] dk);
      step(1'b1, r, 1'b0, g, prev, 1'b0);
      repeat (3) step(1'b1, r, 1'b0, g, dk, 1'b0);
      step(1'b1, r, 1'b0, 4'b0000, dk, 1'b1);
      step(1'b1, r, 1'b0, 4'b0000, dk, 1'b0);
   endtask

   always @(negedge clk) begin
      exp_t e;
      if (q.size() > 0) begin
         e = q.pop_front();
         checks++;
         if (bus.grant !== e.grant || bus.seg_out !== e.seg ||
             bus.slot_done !== e.sd || bus.active !== (|e.grant)) begin
            errors++;
            $display("FAIL step%0d: grant=%b seg_out=%h slot_done=%b active=%b, required grant=%b seg_out=%h slot_done=%b active=%b",
                     e.idx, bus.grant, bus.seg_out, bus.slot_done, bus.active,
                     e.grant, e.seg, e.sd, |e.grant);
         end
      end
   end

   initial begin
      clk      = 1'b0;
      reset    = 1'b0;
      checks   = 0;
      errors   = 0;
      step_no  = 0;
      dv       = '0;
      bus.req  = 4'b0000;
      bus.hold = 1'b0;
      bus.d0   = '0;
      bus.d1   = '0;
      bus.d2   = '0;
      bus.d3   = '0;

      // reset, then idle with no requests
      step(1'b0, 4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0);
      repeat (3) step(1'b1, 4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0);

      // sole requester: 4-cycle grant, slot_done, 2-cycle gap, regrant, release
      dv = {16'h0000, 16'h0000, 16'h0000, 16'h1234};
      slot(4'b0001, 4'b0001, 16'h0000, 16'h1234);
      step(1'b1, 4'b0001, 1'b0, 4'b0001, 16'h1234, 1'b0);
      step(1'b1, 4'b0000, 1'b0, 4'b0000, 16'h1234, 1'b0);
      step(1'b1, 4'b0000, 1'b0, 4'b0000, 16'h1234, 1'b0);
      step(1'b0, 4'b0000, 1'b0, 4'b0000, 16'h0000, 1'b0);

      // all four request: rotation 0,1,2,3,0
      dv = {16'hD000, 16'hC000, 16'hB000, 16'hA000};
      slot(4'b1111, 4'b0001, 16'h0000, 16'hA000);
      slot(4'b1111, 4'b0010, 16'hA000, 16'hB000);
      slot(4'b1111, 4'b0100, 16'hB000, 16'hC000);
      slot(4'b1111, 4'b1000, 16'hC000, 16'hD000);
      slot(4'b1111, 4'b0001, 16'hD000, 16'hA000);

      // src 1 drops its request at cnt=1, next grant goes to src 2
      step(1'b1, 4'b1111, 1'b0, 4'b0010, 16'hA000, 1'b0);
      step(1'b1, 4'b1111, 1'b0, 4'b0010, 16'hB000, 1'b0);
      step(1'b1, 4'b0101, 1'b0, 4'b0000, 16'hB000, 1'b0);
      step(1'b1, 4'b0101, 1'b0, 4'b0000, 16'hB000, 1'b0);
      step(1'b1, 4'b0101, 1'b0, 4'b0100, 16'hB000, 1'b0);
      step(1'b1, 4'b0001, 1'b0, 4'b0000, 16'hC000, 1'b0);
      step(1'b1, 4'b0001, 1'b0, 4'b0000, 16'hC000, 1'b0);
      step(1'b1, 4'b0011, 1'b0, 4'b0001, 16'hC000, 1'b0);

      // hold for 10 cycles during src 0 slot, live d0 change, other req bits toggling
      step(1'b1, 4'b0011, 1'b0, 4'b0001, 16'hA000, 1'b0);
      for (int i = 0; i < 10; i++) begin
         if (i == 4) dv[15:0] = 16'hA5A5;
         step(1'b1, (i % 2 == 1) ? 4'b1011 : 4'b0011, 1'b1, 4'b0001,
              (i < 4) ? 16'hA000 : 16'hA5A5, 1'b0);
      end
      step(1'b1, 4'b0011, 1'b0, 4'b0000, 16'hA5A5, 1'b1);
      step(1'b1, 4'b0011, 1'b0, 4'b0000, 16'hA5A5, 1'b0);
      step(1'b1, 4'b0011, 1'b0, 4'b0010, 16'hA5A5, 1'b0);

      // release at cnt=3 wins over timeout: no slot_done
      step(1'b1, 4'b0011, 1'b0, 4'b0010, 16'hB000, 1'b0);
      step(1'b1, 4'b0011, 1'b0, 4'b0010, 16'hB000, 1'b0);
      step(1'b1, 4'b0011, 1'b0, 4'b0010, 16'hB000, 1'b0);
      step(1'b1, 4'b0001, 1'b0, 4'b0000, 16'hB000, 1'b0);
      step(1'b1, 4'b0001, 1'b0, 4'b0000, 16'hB000, 1'b0);
      step(1'b1, 4'b0001, 1'b0, 4'b0001, 16'hB000, 1'b0);
      step(1'b1, 4'b0001, 1'b0, 4'b0001, 16'hA5A5, 1'b0);

      // reset mid-slot, then ptr restarts at 0 and wraps from src 3
      step(1'b0, 4'b0001, 1'b0, 4'b0000, 16'h0000, 1'b0);
      step(1'b1, 4'b1000, 1'b0, 4'b1000, 16'h0000, 1'b0);
      step(1'b1, 4'b1000, 1'b0, 4'b1000, 16'hD000, 1'b0);
      step(1'b1, 4'b0000, 1'b0, 4'b0000, 16'hD000, 1'b0);
      step(1'b1, 4'b1010, 1'b0, 4'b0000, 16'hD000, 1'b0);
      step(1'b1, 4'b1010, 1'b0, 4'b0010, 16'hD000, 1'b0);
      step(1'b1, 4'b1010, 1'b0, 4'b0010, 16'hB000, 1'b0);
      step(1'b1, 4'b0000, 1'b0, 4'b0000, 16'hB000, 1'b0);
      step(1'b1, 4'b0000, 1'b0, 4'b0000, 16'hB000, 1'b0);
      step(1'b1, 4'b0000, 1'b0, 4'b0000, 16'hB000, 1'b0);

      for (int i = 0; i < 10 && q.size() > 0; i++) @(negedge clk);
      #1;
      if (q.size() != 0) begin
         checks++;
         errors++;
         $display("FAIL drain: pending=%0d, required 0", q.size());
      end

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
